sseg_score_capture: RTL and testbench

- Receive-side counterpart of the score display's multiplexed seven-segment output.
- Samples the active-low `an`/`sseg` bus as it scans, decodes each segment pattern back to a BCD digit, assembles a full 4-digit frame, and converts it sequentially to a 14-bit binary score with a one-cycle valid pulse.
- Used for high-score comparison and as a self-checking monitor of the display path.

---
 rtl/sseg_score_capture.sv | 215 +++++++++++++++++++++
 tb/tb_sseg_score_capture.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sseg_score_capture.sv
// sseg_score_capture: rebuilds a 4-digit BCD frame from a scanned active-low 7-seg bus and converts it to binary.
// Optional SSEG_CAPTURE_CHANGE_ONLY_EN: publish only when {score, frame_err} changes (first frame after reset always).
module sseg_score_capture #(
  parameter int SETTLE_CYCLES = 16,
  parameter int CNT_W         = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  sseg,
  input  logic [3:0]  an,
  output logic [13:0] score,
  output logic        score_valid,
  output logic        frame_err,
  output logic        busy
);

  localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_CAP = CNT_W'(SETTLE_CYCLES - 1);

  // COLLECT: wait for a full frame | CONVERT: four acc*10+digit steps | DONE: publish result
  typedef enum logic [1:0] {
    S_COLLECT = 2'd0,
    S_CONVERT = 2'd1,
    S_DONE    = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [3:0]       an_q, an_p_q;
  logic [7:0]       sseg_q, sseg_p_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       seen_q, seen_d;
  logic [3:0][3:0]  dig_q, dig_d;
  logic [3:0]       err_q, err_d;
  logic [3:0][3:0]  cv_dig_q, cv_dig_d;
  logic             cv_err_q, cv_err_d;
  logic [13:0]      acc_q, acc_d;
  logic [1:0]       step_q, step_d;
  logic [13:0]      score_q, score_d;
  logic             frame_err_q, frame_err_d;
  logic             valid_q, valid_d;

  logic             stable, legal, capture, frame_latch, publish;
  logic             conv_en, done_en;
  logic [3:0]       pos_oh, dec_digit;
  logic             dec_bad;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      an_q     <= 4'hF;
      an_p_q   <= 4'hF;
      sseg_q   <= 8'hFF;
      sseg_p_q <= 8'hFF;
    end else begin
      an_q     <= an;
      an_p_q   <= an_q;
      sseg_q   <= sseg;
      sseg_p_q <= sseg_q;
    end
  end

  always_comb begin
    legal = 1'b0;
    case (an_q)
      4'b1110, 4'b1101, 4'b1011, 4'b0111: legal = 1'b1;
      default:                            legal = 1'b0;
    endcase
  end

  assign pos_oh = ~an_q;

  always_comb begin
    dec_digit = 4'd0;
    dec_bad   = 1'b0;
    case (sseg_q)
      8'h81:   dec_digit = 4'd0;
      8'hCF:   dec_digit = 4'd1;
      8'h92:   dec_digit = 4'd2;
      8'h86:   dec_digit = 4'd3;
      8'hCC:   dec_digit = 4'd4;
      8'hA4:   dec_digit = 4'd5;
      8'hA0:   dec_digit = 4'd6;
      8'h8F:   dec_digit = 4'd7;
      8'h80:   dec_digit = 4'd8;
      8'h84:   dec_digit = 4'd9;
      8'hFF:   dec_digit = 4'd0;
      default: dec_bad   = 1'b1;
    endcase
  end

  assign stable  = (an_q == an_p_q) && (sseg_q == sseg_p_q);
  assign capture = legal && stable && (cnt_q == CNT_CAP);

  always_comb begin
    cnt_d = cnt_q;
    if (!legal || !stable) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_SAT) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // A full mask waits here while a conversion is in flight, so no frame is dropped.
  assign frame_latch = (state_q == S_COLLECT) && (seen_q == 4'hF);

  always_comb begin
    seen_d   = frame_latch ? 4'h0 : seen_q;
    dig_d    = dig_q;
    err_d    = err_q;
    cv_dig_d = cv_dig_q;
    cv_err_d = cv_err_q;
    if (frame_latch) begin
      cv_dig_d = dig_q;
      cv_err_d = |err_q;
    end
    if (capture) begin
      seen_d = seen_d | pos_oh;
      for (int i = 0; i < 4; i++) begin
        if (pos_oh[i]) begin
          dig_d[i] = dec_digit;
          err_d[i] = dec_bad;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_COLLECT;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_COLLECT: if (frame_latch) state_d = S_CONVERT;
      S_CONVERT: if (step_q == 2'd3) state_d = S_DONE;
      S_DONE:    state_d = S_COLLECT;
      default:   state_d = S_COLLECT;
    endcase
  end

  always_comb begin
    conv_en = 1'b0;
    done_en = 1'b0;
    case (state_q)
      S_CONVERT: conv_en = 1'b1;
      S_DONE:    done_en = 1'b1;
      default: ;
    endcase
  end

  assign busy = conv_en;

  always_comb begin
    step_d = step_q;
    acc_d  = acc_q;
    if (frame_latch) begin
      step_d = 2'd0;
      acc_d  = 14'd0;
    end else if (conv_en) begin
      step_d = step_q + 2'd1;
      acc_d  = (acc_q << 3) + (acc_q << 1) + {10'd0, cv_dig_q[2'd3 - step_q]};
    end
  end

`ifdef SSEG_CAPTURE_CHANGE_ONLY_EN
  logic first_q;

  assign publish = done_en &&
                   (first_q || ({acc_q, cv_err_q} != {score_q, frame_err_q}));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       first_q <= 1'b1;
    else if (publish) first_q <= 1'b0;
  end
`else
  assign publish = done_en;
`endif

  assign score_d     = publish ? acc_q : score_q;
  assign frame_err_d = publish ? cv_err_q : frame_err_q;
  assign valid_d     = publish;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q       <= '0;
      seen_q      <= 4'h0;
      dig_q       <= '0;
      err_q       <= 4'h0;
      cv_dig_q    <= '0;
      cv_err_q    <= 1'b0;
      acc_q       <= 14'd0;
      step_q      <= 2'd0;
      score_q     <= 14'd0;
      frame_err_q <= 1'b0;
      valid_q     <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      seen_q      <= seen_d;
      dig_q       <= dig_d;
      err_q       <= err_d;
      cv_dig_q    <= cv_dig_d;
      cv_err_q    <= cv_err_d;
      acc_q       <= acc_d;
      step_q      <= step_d;
      score_q     <= score_d;
      frame_err_q <= frame_err_d;
      valid_q     <= valid_d;
    end
  end

  assign score       = score_q;
  assign frame_err   = frame_err_q;
  assign score_valid = valid_q;

endmodule

// File: tb/tb_sseg_score_capture.sv
// Testbench for sseg_score_capture: scans digit frames onto the an/sseg bus and checks published scores
// against a frame-level model (decimal arithmetic over decoded digits, change-only publishing when enabled).
module tb_sseg_score_capture;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  sseg;
  logic [3:0]  an;
  logic [13:0] score;
  logic        score_valid;
  logic        frame_err;
  logic        busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int s;
    bit e;
  } pulse_t;

  pulse_t pq[$];
  pulse_t mon_p;
  logic   prev_valid = 1'b0;

  logic [7:0] seg_tab [10] = '{8'h81, 8'hCF, 8'h92, 8'h86, 8'hCC,
                               8'hA4, 8'hA0, 8'h8F, 8'h80, 8'h84};
  int weight [4] = '{1, 10, 100, 1000};

  bit have_held = 1'b0;
  int held_s    = 0;
  bit held_e    = 1'b0;

  sseg_score_capture dut (
    .clk         (clk),
    .reset       (reset),
    .sseg        (sseg),
    .an          (an),
    .score       (score),
    .score_valid (score_valid),
    .frame_err   (frame_err),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Pulse monitor: records every published result and checks the pulse is one cycle wide.
  always @(negedge clk) begin
    if (score_valid) begin
      mon_p.s = int'(score);
      mon_p.e = frame_err;
      pq.push_back(mon_p);
      checks++;
      if (prev_valid) begin
        errors++;
        $display("FAIL valid_width: score_valid high on two consecutive cycles, required a one-cycle pulse");
      end
    end
    prev_valid <= score_valid;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // Frame-level reference: decode each position from the display table and weight it decimally.
  function automatic void frame_value(input logic [3:0][7:0] segs, output int s, output bit e);
    s = 0;
    e = 1'b0;
    for (int i = 0; i < 4; i++) begin
      int d;
      bit found;
      d = 0;
      found = 1'b0;
      for (int k = 0; k < 10; k++) begin
        if (seg_tab[k] == segs[i]) begin
          d = k;
          found = 1'b1;
        end
      end
      if (!found && segs[i] != 8'hFF) e = 1'b1;
      s += d * weight[i];
    end
  endfunction

  function automatic bit model_publish(input int s, input bit e);
    bit p;
`ifdef SSEG_CAPTURE_CHANGE_ONLY_EN
    p = !have_held || (s != held_s) || (e != held_e);
`else
    p = 1'b1;
`endif
    if (p) begin
      have_held = 1'b1;
      held_s    = s;
      held_e    = e;
    end
    return p;
  endfunction

  function automatic logic [7:0] rand_seg();
    int r;
    logic [7:0] b;
    bit ok;
    r = $urandom_range(0, 19);
    if (r < 16) return seg_tab[r % 10];
    if (r < 18) return 8'hFF;
    b = 8'h00;
    ok = 1'b0;
    while (!ok) begin
      b = 8'($urandom_range(0, 255));
      ok = (b != 8'hFF);
      for (int k = 0; k < 10; k++) if (seg_tab[k] == b) ok = 1'b0;
    end
    return b;
  endfunction

  task automatic drive_digit(input int pos, input logic [7:0] seg, input int dwell);
    @(negedge clk);
    an   = ~(4'b0001 << pos);
    sseg = seg;
    repeat (dwell) @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    an   = 4'hF;
    sseg = 8'hFF;
  endtask

  task automatic scan_frame(input logic [3:0][7:0] segs, input int dwell, input bit shuffle);
    int ord [4];
    for (int i = 0; i < 4; i++) ord[i] = i;
    if (shuffle) begin
      for (int i = 3; i > 0; i--) begin
        int j;
        int t;
        j = $urandom_range(0, i);
        t = ord[i];
        ord[i] = ord[j];
        ord[j] = t;
      end
    end
    for (int k = 0; k < 4; k++) drive_digit(ord[k], segs[ord[k]], dwell);
  endtask

  task automatic check_frame(input string name, input int s, input bit e);
    pulse_t p;
    if (model_publish(s, e)) begin
      for (int i = 0; i < 60 && pq.size() == 0; i++) @(negedge clk);
      checks++;
      if (pq.size() == 0) begin
        errors++;
        $display("FAIL %s_timeout: no score_valid within 60 cycles, required score %0d err %0d", name, s, e);
      end else begin
        p = pq.pop_front();
        if (p.s !== s || p.e !== e) begin
          errors++;
          $display("FAIL %s: got score %0d err %0d, required score %0d err %0d", name, p.s, p.e, s, e);
        end
      end
    end else begin
      repeat (40) @(negedge clk);
      checks++;
      if (pq.size() != 0) begin
        errors++;
        $display("FAIL %s_nopulse: got %0d pulses, required 0 (unchanged value)", name, pq.size());
        pq.delete();
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    an    = 4'hF;
    sseg  = 8'hFF;
    repeat (3) @(negedge clk);
    checks++;
    if (score !== 14'd0 || score_valid !== 1'b0 || frame_err !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: got score %0d valid %0b err %0b busy %0b, required all 0",
               score, score_valid, frame_err, busy);
    end
    reset = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_basic();
    logic [3:0][7:0] segs;
    int lat;
    int busy_cnt;
    segs = {8'h81, 8'h81, 8'hCC, 8'h92};
    for (int i = 0; i < 3; i++) drive_digit(i, segs[i], 32);
    @(negedge clk);
    an   = 4'b0111;
    sseg = segs[3];
    lat = 0;
    busy_cnt = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (score_valid && lat == 0) lat = i;
    end
    idle();
    checks++;
    if (lat != 24) begin
      errors++;
      $display("FAIL basic_latency: score_valid after %0d cycles from last digit drive, required 24", lat);
    end
    checks++;
    if (busy_cnt != 4) begin
      errors++;
      $display("FAIL basic_busy: busy high for %0d cycles, required 4", busy_cnt);
    end
    check_frame("basic_42", 42, 1'b0);
  endtask

  task automatic test_max();
    scan_frame({4{8'h84}}, 25, 1'b0);
    idle();
    check_frame("max_9999", 9999, 1'b0);
  endtask

  task automatic test_illegal_seg();
    scan_frame({8'h86, 8'h81, 8'hAA, 8'h92}, 25, 1'b0);
    idle();
    check_frame("illegal_seg", 3002, 1'b1);
  endtask

  task automatic test_short_dwell();
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < 4; i++) drive_digit(i, seg_tab[(i + 3) % 10], 10);
    idle();
    repeat (40) @(negedge clk);
    checks++;
    if (pq.size() != 0) begin
      errors++;
      $display("FAIL short_dwell: got %0d pulses, required 0", pq.size());
      pq.delete();
    end
  endtask

  task automatic test_illegal_an();
    drive_digit(1, 8'h8F, 25);
    drive_digit(2, 8'h80, 25);
    drive_digit(3, 8'hA0, 25);
    @(negedge clk);
    an   = 4'b1100;
    sseg = 8'h84;
    repeat (30) @(posedge clk);
    @(negedge clk);
    an   = 4'b1111;
    repeat (30) @(posedge clk);
    repeat (30) @(negedge clk);
    checks++;
    if (pq.size() != 0) begin
      errors++;
      $display("FAIL illegal_an: got %0d pulses with an 1100/1111, required 0", pq.size());
      pq.delete();
    end
    drive_digit(0, 8'hA4, 25);
    idle();
    check_frame("illegal_an_frame", 6875, 1'b0);
  endtask

  task automatic test_back_to_back();
    int n_exp;
    pulse_t p;
    n_exp = 0;
    for (int f = 0; f < 3; f++) begin
      scan_frame({8'hCF, 8'h92, 8'h86, 8'hCC}, 20, 1'b0);
      if (model_publish(1234, 1'b0)) n_exp++;
    end
    idle();
    repeat (40) @(negedge clk);
    checks++;
    if (pq.size() != n_exp) begin
      errors++;
      $display("FAIL back_to_back_count: got %0d pulses, required %0d", pq.size(), n_exp);
    end
    while (pq.size() > 0) begin
      p = pq.pop_front();
      checks++;
      if (p.s !== 1234 || p.e !== 1'b0) begin
        errors++;
        $display("FAIL back_to_back_value: got score %0d err %0d, required 1234 err 0", p.s, p.e);
      end
    end
  endtask

  task automatic test_random();
    logic [3:0][7:0] segs;
    int s;
    bit e;
    segs = {8'hCF, 8'h92, 8'h86, 8'hCC};
    for (int f = 0; f < 10; f++) begin
      if ($urandom_range(0, 3) != 0)
        for (int i = 0; i < 4; i++) segs[i] = rand_seg();
      frame_value(segs, s, e);
      scan_frame(segs, $urandom_range(20, 30), 1'b1);
      idle();
      check_frame("random_frame", s, e);
    end
  endtask

  task automatic test_reset_mid_convert();
    int waited;
    drive_digit(0, 8'h80, 25);
    drive_digit(1, 8'h8F, 25);
    drive_digit(2, 8'hA0, 25);
    @(negedge clk);
    an   = 4'b0111;
    sseg = 8'hA4;
    waited = 0;
    while (!busy && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (!busy) begin
      errors++;
      $display("FAIL reset_mid_busy: busy never rose within 40 cycles, required 1");
    end
    @(negedge clk);
    reset = 1'b0;
    an    = 4'hF;
    sseg  = 8'hFF;
    #1;
    checks++;
    if (score !== 14'd0 || score_valid !== 1'b0 || frame_err !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_outputs: got score %0d valid %0b err %0b busy %0b, required all 0",
               score, score_valid, frame_err, busy);
    end
    have_held = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (40) @(negedge clk);
    checks++;
    if (pq.size() != 0) begin
      errors++;
      $display("FAIL reset_mid_nopulse: got %0d pulses after reset, required 0", pq.size());
      pq.delete();
    end
    scan_frame({8'hCC, 8'h86, 8'h92, 8'hCF}, 25, 1'b0);
    idle();
    check_frame("after_reset_4321", 4321, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_max();
    test_illegal_seg();
    test_short_dwell();
    test_illegal_an();
    test_back_to_back();
    test_random();
    test_reset_mid_convert();
    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
